// File: rtl/pulse_stretch.sv
// Per-lane pulse stretcher: each accepted input pulse drives level_out high for LENGTH cycles.
// Define PULSE_STRETCH_RETRIGGER_EN to let a pulse on a busy lane restart its stretch.
module pulse_stretch #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] level_out,
  output logic                  active
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LOAD = CW'(LENGTH);

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_lane
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          level_q;
      logic          level_d;
      logic          busy;
      logic          accept;

      always_comb begin
        busy = (cnt_q != '0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
        accept = en & in[gi];
`else
        // A lane still counting down (even at 1) ignores new pulses.
        accept = en & in[gi] & ~busy;
`endif
        if (accept) begin
          cnt_d = LOAD;
        end else if (busy) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = '0;
        end
        // Output flop tracks the next counter value so it rises one edge after the pulse.
        level_d = (cnt_d != '0);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign level_out[gi] = level_q;
    end
  endgenerate

  assign active = |level_out;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch (DATA_WIDTH=8, LENGTH=4); directed scenarios
// plus randomized traffic compared against a timestamp-based reference model.
module tb_pulse_stretch;
  localparam int DW  = 8;
  localparam int LEN = 4;

  logic          clk;
  logic          rst_s;
  logic          en_s;
  logic [DW-1:0] in_s;
  logic [DW-1:0] level_out;
  logic          active;

  int checks = 0;
  int errors = 0;

  pulse_stretch #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk      (clk),
    .rst      (rst_s),
    .en       (en_s),
    .in       (in_s),
    .level_out(level_out),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a lane is high after edge k iff its last accepted pulse was
  // at an edge a with k - a < LEN. A lane is busy at edge k if it was high after k-1.
  int edge_n = 0;
  int last_acc [DW];

  function automatic logic [DW-1:0] model_level();
    logic [DW-1:0] v;
    v = '0;
    for (int l = 0; l < DW; l++) v[l] = ((edge_n - last_acc[l]) < LEN);
    return v;
  endfunction

  function automatic void model_step(logic [DW-1:0] i, logic e, logic r);
    logic [DW-1:0] prev;
    prev = model_level();
    edge_n++;
    for (int l = 0; l < DW; l++) begin
      if (r) begin
        last_acc[l] = -100000;
      end else if (e && i[l]) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        last_acc[l] = edge_n;
`else
        if (!prev[l]) last_acc[l] = edge_n;
`endif
      end
    end
  endfunction

  // Apply one set of inputs across one rising edge, then settle 1 time unit past it.
  task automatic tick(input logic [DW-1:0] i, input logic e, input logic r);
    in_s  = i;
    en_s  = e;
    rst_s = r;
    @(posedge clk);
    model_step(i, e, r);
    #1;
    $display("txn %0d rst=%0b en=%0b in=%02h level_out=%02h active=%0b",
             edge_n, r, e, i, level_out, active);
  endtask

  task automatic go_idle();
    for (int k = 0; k < LEN + 1; k++) tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      tick(8'hFF, 1'b1, 1'b1);
      checks++;
      if (level_out !== 8'h00 || active !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d level_out=%02h active=%0b expected 00/0", k, level_out, active);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick(8'h00, 1'b1, 1'b0);
      checks++;
      if (level_out !== 8'h00 || active !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d level_out=%02h active=%0b expected 00/0", k, level_out, active);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [DW-1:0] exp_v;
    go_idle();
    tick(8'h01, 1'b1, 1'b0);
    for (int k = 0; k < LEN + 2; k++) begin
      if (k > 0) tick(8'h00, 1'b1, 1'b0);
      exp_v = (k < LEN) ? 8'h01 : 8'h00;
      checks++;
      if (level_out !== exp_v || active !== (exp_v != 0)) begin
        errors++;
        $display("FAIL single_pulse t+%0d level_out=%02h active=%0b expected %02h", k, level_out, active, exp_v);
      end
    end
  endtask

  task automatic test_enable_gate();
    logic [DW-1:0] exp_v;
    go_idle();
    tick(8'h0F, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0);
    checks++;
    if (level_out !== 8'h00 || active !== 1'b0) begin
      errors++;
      $display("FAIL enable_discard level_out=%02h active=%0b expected 00/0", level_out, active);
    end
    tick(8'h02, 1'b1, 1'b0);
    for (int k = 0; k < LEN + 2; k++) begin
      if (k > 0) tick(8'h02, 1'b0, 1'b0);
      exp_v = (k < LEN) ? 8'h02 : 8'h00;
      checks++;
      if (level_out !== exp_v) begin
        errors++;
        $display("FAIL enable_low_stretch t+%0d level_out=%02h expected %02h", k, level_out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_v;
    int hi_edges;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    hi_edges = 6;
`else
    hi_edges = 4;
`endif
    go_idle();
    for (int k = 0; k < 8; k++) begin
      tick((k == 0 || k == 2) ? 8'h80 : 8'h00, 1'b1, 1'b0);
      exp_v = (k < hi_edges) ? 8'h80 : 8'h00;
      checks++;
      if (level_out !== exp_v) begin
        errors++;
        $display("FAIL repulse t+%0d level_out=%02h expected %02h", k, level_out, exp_v);
      end
    end
  endtask

  task automatic test_continuous();
    logic exp_b;
    go_idle();
    for (int k = 0; k < 18; k++) begin
      tick((k < 12) ? 8'h01 : 8'h00, 1'b1, 1'b0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
      exp_b = (k < 15);
`else
      exp_b = (k < 12) ? ((k % 5) < 4) : (k < 14);
`endif
      checks++;
      if (level_out !== {7'b0, exp_b}) begin
        errors++;
        $display("FAIL continuous t+%0d level_out=%02h expected %02h", k, level_out, {7'b0, exp_b});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_tab [4];
    logic [DW-1:0] in_tab  [4];
    logic          rst_tab [4];
    exp_tab = '{8'h03, 8'h0F, 8'h00, 8'h00};
    in_tab  = '{8'h03, 8'h0C, 8'hFF, 8'h00};
    rst_tab = '{1'b0, 1'b0, 1'b1, 1'b0};
    go_idle();
    for (int k = 0; k < 4; k++) begin
      tick(in_tab[k], 1'b1, rst_tab[k]);
      checks++;
      if (level_out !== exp_tab[k] || active !== (exp_tab[k] != 0)) begin
        errors++;
        $display("FAIL reset_mid t+%0d level_out=%02h active=%0b expected %02h", k, level_out, active, exp_tab[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] i;
    logic          e;
    logic          r;
    logic [DW-1:0] exp_v;
    for (int k = 0; k < 400; k++) begin
      i = DW'($urandom) & DW'($urandom);
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 49) == 0);
      tick(i, e, r);
      exp_v = model_level();
      checks++;
      if (level_out !== exp_v || active !== (exp_v != 0)) begin
        errors++;
        $display("FAIL random n=%0d level_out=%02h active=%0b expected %02h", k, level_out, active, exp_v);
      end
    end
  endtask

  initial begin
    for (int l = 0; l < DW; l++) last_acc[l] = -100000;
    rst_s = 1'b1;
    en_s  = 1'b0;
    in_s  = '0;
    test_reset();
    test_single_pulse();
    test_enable_gate();
    test_back_to_back();
    test_continuous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of independent lanes.
REQ-002 Parameter LENGTH, default 4: output high time in clk cycles per accepted pulse; legal range 1..255.
REQ-003 clk  input  1  rising-edge system clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  capture enable; when low, new input pulses are not accepted.
REQ-006 in  input  DATA_WIDTH  per-lane single-cycle (or longer) pulse requests, sampled on clk rising edge.
REQ-007 level_out  output  DATA_WIDTH  per-lane stretched level, registered.
REQ-008 active  output  1  OR-reduction of level_out; combinational from registered state.

Function
REQ-009 Each lane SHALL hold one down-counter of width ceil(log2(LENGTH+1)); lane idle when counter = 0, busy otherwise.
REQ-010 level_out[i] SHALL equal (counter[i] != 0), driven from a register with no combinational path from in or en.
REQ-011 Accept: idle lane, en=1, in[i]=1 sampled at edge t -> counter[i] loads LENGTH at edge t, level_out[i] high for exactly LENGTH cycles after edge t, low after edge t+LENGTH.
REQ-012 Latency from sampled pulse to level_out rise SHALL be exactly 1 clk edge.
REQ-013 Busy lane SHALL decrement its counter by 1 every cycle regardless of en; en gates acceptance only.
REQ-014 Pulses with en=0 SHALL be discarded, never queued or remembered.
REQ-015 Counter SHALL never underflow; counter 0 with no accept stays 0.
REQ-016 Lanes SHALL be fully independent; simultaneous pulses on several lanes each behave as if alone.
REQ-017 LENGTH=1 SHALL yield level_out as a 1-cycle-delayed copy of (in & en) for isolated pulses.
REQ-018 Pulse arriving while busy: behaviour per REQ-021/REQ-022.

Reset
REQ-019 rst=1 at a clock edge SHALL zero every counter; level_out=0 and active=0 from that edge; rst has priority over en and in.
REQ-020 rst asserted mid-stretch SHALL terminate the stretch immediately; a pulse sampled in the same cycle as rst is discarded.

Configuration
REQ-021 Macro PULSE_STRETCH_RETRIGGER_EN defined: en=1 and in[i]=1 on a busy lane reloads counter[i] to LENGTH, so level_out[i] stays high until LENGTH cycles after the last accepted pulse; continuous in=1 holds level_out[i] high continuously.
REQ-022 Macro undefined: pulses on a busy lane (including counter=1) SHALL be ignored; continuous in=1 with en=1 yields LENGTH cycles high, 1 cycle low, repeating with period LENGTH+1.
REQ-023 Ports, parameters, reset behaviour and latency SHALL be identical in both builds.

Verification (DATA_WIDTH=8, LENGTH=4)
REQ-024 Reset: rst=1 for 2 cycles with in=8'hFF, en=1 -> level_out=8'h00, active=0 throughout; after release, in=0 -> outputs stay 0.
REQ-025 Single pulse: in=8'h01 for 1 cycle at edge t -> level_out=8'h01 after edges t..t+3, 8'h00 after edge t+4; active mirrors.
REQ-026 Enable gate: in=8'h0F with en=0 for 1 cycle -> level_out stays 8'h00; en=0 during an active stretch -> stretch still ends after exactly 4 cycles.
REQ-027 Re-pulse on busy lane: in=8'h80 at edges t and t+2 -> with PULSE_STRETCH_RETRIGGER_EN, bit 7 high after edges t..t+5; without, high after edges t..t+3 only.
REQ-028 Continuous input: in=8'h01 held 12 cycles, en=1 -> with macro, bit 0 high continuously until 4 cycles after in drops; without, pattern HHHHL repeated.
REQ-029 Reset mid-stretch and independent lanes: in=8'h03 at t, in=8'h0C at t+1, rst=1 at t+2 -> level_out 8'h03 after t, 8'h0F after t+1, 8'h00 after t+2.
